fifo_rr_read_arbiter: RTL and testbench

Round-robin read scheduler that drains up to N synchronous FIFOs into one valid/ready output stream. Each FIFO has a registered read port, so data appears one cycle after its read strobe. The block issues at most one read strobe per cycle to a non-empty, enabled FIFO and captures the returned word with its source index. A 2-entry output buffer absorbs downstream back-pressure, so no returned word is ever lost. It sits between the per-channel sync FIFOs and a shared single-port consumer such as a packer or bus master.

---
 rtl/fifo_rr_read_arbiter_if.sv | 28 ++
 rtl/fifo_rr_read_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_rr_read_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_read_arbiter_if.sv
// Bundle between the round-robin FIFO read arbiter and its FIFOs and downstream consumer.
// master = arbiter side, slave = FIFOs/consumer side.
interface fifo_rr_read_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(N);

    logic [N-1:0]       src_en;
    logic [N-1:0]       fifo_empty;
    logic [N-1:0]       fifo_rinc;
    logic [N*WIDTH-1:0] fifo_rdata;
    logic               m_valid;
    logic               m_ready;
    logic [WIDTH-1:0]   m_data;
    logic [SW-1:0]      m_src;
    logic               busy;

    modport master (
        input  src_en, fifo_empty, fifo_rdata, m_ready,
        output fifo_rinc, m_valid, m_data, m_src, busy
    );

    modport slave (
        output src_en, fifo_empty, fifo_rdata, m_ready,
        input  fifo_rinc, m_valid, m_data, m_src, busy
    );
endinterface

// File: rtl/fifo_rr_read_arbiter.sv
// Round-robin read scheduler draining N registered-read FIFOs into one valid/ready stream.
// Latency: strobe in t, data captured end of t+1, m_valid in t+2; one word/cycle sustained.
// Backpressure: 2-entry output buffer; strobes stop when buffered + in-flight words would exceed 2.
module fifo_rr_read_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SW   = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fifo_rr_read_arbiter_if.master bus
);
    localparam int SWP = SW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [SW-1:0]    src;
    } entry_t;

    logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             inflight_vld_q, inflight_vld_d;
    logic [SW-1:0]    inflight_src_q, inflight_src_d;
    logic [1:0]       occ_q, occ_d;
    entry_t           buf0_q, buf0_d, buf1_q, buf1_d;

    logic [N-1:0]     req;
    logic             pop;
    logic             push;
    logic             space;
    logic             grant_vld;
    logic             grant;
    logic [SW-1:0]    grant_idx;
    logic [2:0]       committed;
    logic [WIDTH-1:0] rdata_arr [N];
    entry_t           push_ent;

    assign req       = bus.src_en & ~bus.fifo_empty;
    assign pop       = (occ_q != 2'd0) & bus.m_ready;
    assign push      = inflight_vld_q;
    // Words already owed to the buffer after this cycle's pop; a new strobe needs room for one more.
    assign committed = {1'b0, occ_q} + {2'b00, inflight_vld_q} - {2'b00, pop};
    assign space     = committed < 3'd2;
    assign grant     = grant_vld & space & rst_n;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rdata_arr[i] = bus.fifo_rdata[i*WIDTH +: WIDTH];
        end
    end

    assign push_ent.dat = rdata_arr[inflight_src_q];
    assign push_ent.src = inflight_src_q;

    // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
    always_comb begin
        logic [SWP-1:0] cand;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + SWP'(k);
            if (cand >= SWP'(N)) begin
                cand = cand - SWP'(N);
            end
            if (req[cand[SW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        bus.fifo_rinc = '0;
        if (grant) begin
            bus.fifo_rinc[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        inflight_vld_d = grant;
        inflight_src_d = inflight_src_q;
        if (grant) begin
            inflight_src_d = grant_idx;
            rr_ptr_d       = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
        end
    end

    // Head lives in buf0; a push alongside a pop lands behind whatever remains.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = push_ent;
                end else begin
                    buf1_d = push_ent;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = push_ent;
                end else begin
                    buf0_d = push_ent;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            inflight_vld_q <= 1'b0;
            inflight_src_q <= '0;
            occ_q          <= 2'd0;
            buf0_q         <= '0;
            buf1_q         <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_src_q <= inflight_src_d;
            occ_q          <= occ_d;
            buf0_q         <= buf0_d;
            buf1_q         <= buf1_d;
        end
    end

    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = buf0_q.dat;
    assign bus.m_src   = buf0_q.src;
    assign bus.busy    = inflight_vld_q | (occ_q != 2'd0);
endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Bench for fifo_rr_read_arbiter: queue-based FIFO models plus a word-level scoreboard
// predicting every strobe and every delivered word from the round-robin and buffering rules.
module tb_fifo_rr_read_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] dat;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_rr_read_arbiter_if #(.N(N), .WIDTH(W)) bus ();
    fifo_rr_read_arbiter #(.N(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [N-1:0] src_en;
    logic [N-1:0] fifo_empty;
    logic         m_ready;
    logic [W-1:0] rdata [N];

    assign bus.src_en     = src_en;
    assign bus.fifo_empty = fifo_empty;
    assign bus.m_ready    = m_ready;
    for (genvar gi = 0; gi < N; gi++) begin : g_rd
        assign bus.fifo_rdata[gi*W +: W] = rdata[gi];
    end

    logic [W-1:0] fq [N][$];
    ent_t         exp_q[$];
    int           m_rr, m_out, m_infl;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           nstrobe [N];
    int           pop_src[$];
    int           pop_cyc[$];
    logic [N-1:0] s_rinc;
    logic         s_valid, s_busy;
    logic [W-1:0] s_data;
    logic [1:0]   s_src;
    bit           hold_prev;
    logic [W-1:0] prev_data;
    logic [1:0]   prev_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) fifo_empty[i] = (fq[i].size() == 0);
    endtask

    task automatic clear_logs();
        pop_src.delete();
        pop_cyc.delete();
        for (int i = 0; i < N; i++) nstrobe[i] = 0;
    endtask

    // Reset entry/exit; outputs must drop as soon as rst_n falls.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_fifo_rinc", bus.fifo_rinc, 0);
        chk("rst_busy", bus.busy, 0);
        for (int i = 0; i < N; i++) begin
            fq[i].delete();
            rdata[i] = '0;
        end
        exp_q.delete();
        m_rr = 0; m_out = 0; m_infl = 0;
        hold_prev = 1'b0;
        refresh();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_src", bus.m_src, 0);
        rst_n = 1'b1;
    endtask

    // One cycle: inputs are already applied; check at negedge, then model the FIFO read port.
    task automatic tick();
        bit           exp_valid, pop;
        logic [N-1:0] req, exp_rinc;
        int           g, idx;
        ent_t         e;
        @(negedge clk);
        s_rinc  = bus.fifo_rinc;
        s_valid = bus.m_valid;
        s_busy  = bus.busy;
        s_data  = bus.m_data;
        s_src   = bus.m_src;
        exp_valid = (m_out - m_infl) > 0;
        pop = exp_valid && m_ready;
        chk("m_valid", s_valid, exp_valid);
        chk("busy", s_busy, m_out > 0);
        req = src_en & ~fifo_empty;
        g = -1;
        if ((m_out - (pop ? 1 : 0)) < 2) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && req[idx]) g = idx;
            end
        end
        exp_rinc = '0;
        if (g >= 0) exp_rinc[g] = 1'b1;
        chk("fifo_rinc", s_rinc, exp_rinc);
        chk("rinc_legal", s_rinc & ~req, 0);
        if (hold_prev) begin
            chk("hold_data", s_data, prev_data);
            chk("hold_src", s_src, prev_src);
        end
        if (pop && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("m_data", s_data, e.dat);
            chk("m_src", s_src, e.src);
            m_out--;
            pop_src.push_back(int'(s_src));
            pop_cyc.push_back(cyc);
        end
        hold_prev = s_valid && !m_ready;
        prev_data = s_data;
        prev_src  = s_src;
        if (g >= 0) begin
            e.src = g[1:0];
            e.dat = fq[g][0];
            exp_q.push_back(e);
            m_out++;
            m_rr = (g + 1) % N;
        end
        m_infl = (g >= 0) ? 1 : 0;
        for (int i = 0; i < N; i++) if (s_rinc[i]) nstrobe[i]++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_rinc[i] && fq[i].size() > 0) rdata[i] = fq[i].pop_front();
        end
        refresh();
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((m_out > 0 || fifo_empty != {N{1'b1}}) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (m_out == 0 && fifo_empty == {N{1'b1}}), 1);
    endtask

    initial begin
        rst_n = 1'b1;
        src_en = '0;
        m_ready = 1'b0;
        fifo_empty = '1;
        for (int i = 0; i < N; i++) rdata[i] = '0;
        #2;

        // Single word from FIFO 2
        do_reset();
        fq[2].push_back(8'hA5);
        src_en = 4'hF; m_ready = 1'b1; refresh();
        tick();
        chk("sw_rinc_c0", s_rinc, 4'b0100);
        tick();
        tick();
        chk("sw_valid_c2", s_valid, 1);
        chk("sw_data_c2", s_data, 8'hA5);
        chk("sw_src_c2", s_src, 2);
        tick();
        chk("sw_busy_c3", s_busy, 0);
        chk("sw_rinc_c3", s_rinc, 0);

        // Round-robin fairness
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) fq[i].push_back(8'(16 * i + k));
        src_en = 4'hF; m_ready = 1'b1; refresh();
        repeat (16) tick();
        chk("rr_count", pop_src.size(), 12);
        for (int j = 0; j < pop_src.size(); j++) chk("rr_src", pop_src[j], j % 4);
        if (pop_cyc.size() == 12) chk("rr_back_to_back", pop_cyc[11] - pop_cyc[0], 11);

        // Back-pressure
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            fq[0].push_back(8'(8'hB0 + k));
            fq[1].push_back(8'(8'hC0 + k));
        end
        src_en = 4'hF; m_ready = 1'b0; refresh();
        repeat (10) tick();
        chk("bp_strobes", nstrobe[0] + nstrobe[1] + nstrobe[2] + nstrobe[3], 2);
        chk("bp_head_data", s_data, 8'hB0);
        chk("bp_head_src", s_src, 0);
        m_ready = 1'b1;
        drain("bp_drain", 40);
        chk("bp_delivered", pop_src.size(), 8);

        // Mask and wrap
        do_reset();
        clear_logs();
        fq[2].push_back(8'h2A);
        src_en = 4'hF; m_ready = 1'b1; refresh();
        tick();
        chk("mw_first", s_rinc, 4'b0100);
        fq[0].push_back(8'h0A);
        fq[3].push_back(8'h3A);
        src_en = 4'b0001; refresh();
        tick();
        chk("mw_wrap_grant0", s_rinc, 4'b0001);
        chk("mw_masked3", nstrobe[3], 0);
        fq[1].push_back(8'h1A);
        src_en = 4'b1011; refresh();
        tick();
        chk("mw_ptr_after0", s_rinc, 4'b0010);
        drain("mw_drain", 20);

        // Single-entry FIFO
        do_reset();
        clear_logs();
        fq[1].push_back(8'h5E);
        src_en = 4'hF; m_ready = 1'b1; refresh();
        repeat (6) tick();
        chk("se_pulses", nstrobe[1], 1);
        chk("se_delivered", pop_src.size(), 1);

        // Reset mid-stream
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fq[0].push_back(8'(8'hD0 + k));
            fq[1].push_back(8'(8'hE0 + k));
        end
        src_en = 4'hF; m_ready = 1'b1; refresh();
        repeat (3) tick();
        do_reset();
        fq[2].push_back(8'h77);
        fq[3].push_back(8'h88);
        src_en = 4'hF; m_ready = 1'b1; refresh();
        tick();
        chk("mr_first_grant", s_rinc, 4'b0100);
        drain("mr_drain", 20);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            src_en  = ($urandom % 5 == 0) ? 4'($urandom) : 4'hF;
            m_ready = ($urandom % 4) != 0;
            if ($urandom % 2 == 1) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (fq[r].size() < 6) fq[r].push_back(8'($urandom));
            end
            refresh();
            tick();
        end
        src_en = 4'hF; m_ready = 1'b1;
        drain("rand_drain", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
